// File: rtl/updown_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package updown_pkg;

   // Selects what happens when an update leaves the range [0, MAX_VALUE]
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Limits a value to an inclusive upper bound
   function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                                input logic [31:0] max);
      return (value > max) ? max : value;
   endfunction

endpackage : updown_pkg

// File: rtl/updown_step_calc.sv
// Combinational next-count computation for one enabled counter update.
// Range checks run on a widened datapath so no carry or borrow is lost.
module updown_step_calc
   import updown_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_VALUE = (2**WIDTH) - 1,
   parameter int unsigned STEP_W    = WIDTH
) (
   input  logic [WIDTH-1:0]  i_count,
   input  logic [STEP_W-1:0] i_step,
   input  logic              i_up_down,
   input  logic              i_sat_mode,
   output logic [WIDTH-1:0]  o_next_count_c,
   output logic              o_ovf_evt_c,
   output logic              o_unf_evt_c
);

   // Wide enough for the larger operand plus carry headroom
   localparam int unsigned CW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 2;

   localparam logic [CW-1:0] MAX_W   = CW'(MAX_VALUE);
   localparam logic [CW-1:0] RANGE_W = CW'(MAX_VALUE + 1);

   logic [CW-1:0] w_count;
   logic [CW-1:0] w_step_raw;
   logic [CW-1:0] w_step_mod;
   logic [CW-1:0] w_step;
   logic [CW-1:0] w_sum;
   logic [CW-1:0] w_wrap_up;
   logic [CW-1:0] w_diff;
   logic [CW-1:0] w_wrap_dn;

   assign w_count    = CW'(i_count);
   assign w_step_raw = CW'(i_step);
   // Wrap mode folds oversized steps into the counting range; sat mode clamps
   assign w_step_mod = w_step_raw % RANGE_W;
   assign w_step     = (i_sat_mode == MODE_SAT) ? w_step_raw : w_step_mod;

   assign w_sum      = w_count + w_step;
   assign w_wrap_up  = w_sum - RANGE_W;
   assign w_diff     = w_count - w_step;
   assign w_wrap_dn  = (w_count + RANGE_W) - w_step;

   // Select in-range result, wrapped result or clamped limit
   always_comb begin
      o_next_count_c = i_count;
      o_ovf_evt_c    = 1'b0;
      o_unf_evt_c    = 1'b0;
      if (i_up_down) begin
         if (w_sum > MAX_W) begin
            o_ovf_evt_c    = 1'b1;
            o_next_count_c = (i_sat_mode == MODE_SAT) ? WIDTH'(MAX_VALUE)
                                                      : WIDTH'(w_wrap_up);
         end else begin
            o_next_count_c = WIDTH'(w_sum);
         end
      end else begin
         if (w_step > w_count) begin
            o_unf_evt_c    = 1'b1;
            o_next_count_c = (i_sat_mode == MODE_SAT) ? '0
                                                      : WIDTH'(w_wrap_dn);
         end else begin
            o_next_count_c = WIDTH'(w_diff);
         end
      end
   end

endmodule : updown_step_calc

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with runtime step, wrap/saturate mode,
// terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_param
   import updown_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_VALUE = (2**WIDTH) - 1,
   parameter int unsigned STEP_W    = WIDTH
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ena,
   input  logic              i_set,
   input  logic [WIDTH-1:0]  i_set_value,
   input  logic              i_up_down,
   input  logic [STEP_W-1:0] i_step,
   input  logic              i_sat_mode,
   input  logic              i_clr_flags,
   output logic [WIDTH-1:0]  o_count,
   output logic              o_tc,
   output logic              o_ovf_flag,
   output logic              o_unf_flag,
   output logic              o_at_max_c,
   output logic              o_at_min_c
);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf_flag;
   logic             r_unf_flag;

   logic [WIDTH-1:0] w_next_count;
   logic             w_ovf_evt;
   logic             w_unf_evt;
   logic             w_do_count;
   logic             w_ovf_hit;
   logic             w_unf_hit;
   logic [WIDTH-1:0] w_load_value;

   updown_step_calc #(
      .WIDTH     (WIDTH),
      .MAX_VALUE (MAX_VALUE),
      .STEP_W    (STEP_W)
   ) u_step_calc (
      .i_count        (r_count),
      .i_step         (i_step),
      .i_up_down      (i_up_down),
      .i_sat_mode     (i_sat_mode),
      .o_next_count_c (w_next_count),
      .o_ovf_evt_c    (w_ovf_evt),
      .o_unf_evt_c    (w_unf_evt)
   );

   // A counting update happens only when no load is pending and step is non-zero
   assign w_do_count   = !i_set && i_ena && (i_step != '0);
   assign w_ovf_hit    = w_do_count && w_ovf_evt;
   assign w_unf_hit    = w_do_count && w_unf_evt;
   assign w_load_value = WIDTH'(clamp_to_max(32'(i_set_value), 32'(MAX_VALUE)));

   // Count register and terminal-count pulse: reset > load > count > hold
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else if (i_set) begin
         r_count <= w_load_value;
         r_tc    <= 1'b0;
      end else if (w_do_count) begin
         r_count <= w_next_count;
         r_tc    <= w_ovf_evt | w_unf_evt;
      end else begin
         r_tc    <= 1'b0;
      end
   end

   // Sticky flags: a new event in the same cycle beats a clear request
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ovf_flag <= 1'b0;
         r_unf_flag <= 1'b0;
      end else begin
         if (w_ovf_hit)        r_ovf_flag <= 1'b1;
         else if (i_clr_flags) r_ovf_flag <= 1'b0;
         if (w_unf_hit)        r_unf_flag <= 1'b1;
         else if (i_clr_flags) r_unf_flag <= 1'b0;
      end
   end

   assign o_count    = r_count;
   assign o_tc       = r_tc;
   assign o_ovf_flag = r_ovf_flag;
   assign o_unf_flag = r_unf_flag;
   assign o_at_max_c = (r_count == WIDTH'(MAX_VALUE));
   assign o_at_min_c = (r_count == '0);

endmodule : updown_counter_param

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter, next generation of the 4-bit up/down counter used in the TT tiles. Adds width/limit parameters, a runtime step size, wrap or saturate mode, a terminal-count pulse, and sticky overflow/underflow flags. It sits as a reusable timing/event-count primitive inside tile top levels and is driven directly by host control bits.

Parameters:
WIDTH, 4, counter width in bits
MAX_VALUE, 2**WIDTH-1, inclusive upper limit; lower limit fixed at 0; must be >= 1 and <= 2**WIDTH-1
STEP_W, WIDTH, width of step input

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, synchronous, active-low
ena  input  1  count enable
set  input  1  load set_value
set_value  input  WIDTH  load value
up_down  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement amount per enabled cycle
sat_mode  input  1  0 = wrap modulo MAX_VALUE+1, 1 = saturate at limits
clr_flags  input  1  clear sticky flags
count  output  WIDTH  current count (registered)
tc  output  1  registered 1-cycle pulse: range limit hit this update
ovf_flag  output  1  sticky: an up update exceeded MAX_VALUE
unf_flag  output  1  sticky: a down update went below 0
at_max  output  1  combinational, count == MAX_VALUE
at_min  output  1  combinational, count == 0

Behaviour:
- Reset: rst_n=0 at a rising edge forces count=0, tc=0, ovf_flag=0, unf_flag=0; this overrides every other input, including mid-count.
- Priority per edge: reset > set > (ena and step != 0) > hold.
- Load: count <= min(set_value, MAX_VALUE); tc=0; flags unchanged. Load wins over ena in the same cycle.
- Arithmetic: computed at WIDTH+2 bits, no truncation before the range check. step is taken modulo MAX_VALUE+1 in wrap mode. Values of step above MAX_VALUE have no special meaning in sat mode; the result simply clamps.
- Up: r = count + step.
  - r <= MAX_VALUE: count <= r.
  - r > MAX_VALUE, wrap mode: count <= r - (MAX_VALUE+1).
  - r > MAX_VALUE, sat mode: count <= MAX_VALUE.
  - Out-of-range case: tc=1 next cycle and ovf_flag set.
- Down: if step <= count, count <= count - step.
  - step > count, wrap mode: count <= count + (MAX_VALUE+1) - step.
  - step > count, sat mode: count <= 0.
  - Out-of-range case: tc=1 and unf_flag set.
- Latency: count, tc and flags update on the same edge, one cycle after the inputs are sampled.
- Saturated hold: tc re-pulses on every enabled cycle in which the requested result is out of range. Example: sat mode, count=0, counting down with step=1 gives tc=1 each cycle.
- Hold: ena=0 or step=0 leaves count unchanged with tc=0.
- Flags: clr_flags=1 clears both. If a new overflow/underflow event occurs in the same cycle, the set wins for that flag.
- No FSM state beyond count/tc/flags; all outputs are deterministic from registered state.

Decomposition:
- Shared package updown_pkg:
  - MODE_WRAP=1'b0 and MODE_SAT=1'b1 constants.
  - Function clamp_to_max(value, max).
- One sub-module: updown_step_calc, combinational. Inputs: count, step, up_down, sat_mode. Outputs: next_count, ovf_evt, unf_evt. The top holds the registers, priority logic and flags.

Test Plan:
Bench instance uses WIDTH=4, MAX_VALUE=9, STEP_W=4; the last case also uses the defaults.
1. rst_n=0 for 1 edge with ena=1, up_down=1, step=1 -> count=0, tc=0, ovf_flag=0, unf_flag=0, at_min=1.
2. set=1, set_value=12 -> count=9, at_max=1. Then set=1, set_value=7 with ena=1, step=3 -> count=7 (load wins), tc=0.
3. Wrap up from count=7, step=2, up_down=1, sat_mode=0, ena=1 -> count 9 (tc=0), then 1 (tc=1 for exactly one cycle, ovf_flag=1), then 3.
4. Sat down from count=1, step=3, up_down=0, sat_mode=1 -> count 0, tc=1, unf_flag=1. Next edge: count stays 0, tc=1. Then ena=0 -> count 0, tc=0.
5. clr_flags=1 in the same cycle as an overflow event -> ovf_flag stays 1. Next cycle clr_flags=1 with no event -> both flags 0.
6. Mid-count reset: counting up at count=5, rst_n=0 for one edge -> count=0, flags 0 on that edge. Release rst_n=1 -> counting resumes at 1.
7. Default parameters (WIDTH=4, MAX_VALUE=15): count=15, step=1, up, wrap -> count 0, tc=1, matching legacy 4-bit counter wrap.
